// File: rtl/pll_lock_rst_ctrl.sv
// Reset sequencer for the memory-interface PLL: pulses pll_rst, qualifies lock over a
// stability window, retries on lock timeout, and releases sys_rst once lock is trusted.
module pll_lock_rst_ctrl #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int MAX_P = (LOCK_TIMEOUT > PLL_RST_CYCLES)
        ? ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES)
        : ((PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES);
    localparam int TW = $clog2(MAX_P);

    localparam logic [TW-1:0] PRST_LAST = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STB_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [1:0]       sync_q, sync_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic             locked_s;
    logic             loss_inc;
    logic             tmo_inc;

    assign locked_s = sync_q[1];

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q + TW'(1);
        sync_d   = {sync_q[0], locked};
        loss_inc = 1'b0;
        tmo_inc  = 1'b0;
        case (state_q)
            S_PLL_RST: begin
                if (tmr_q == PRST_LAST) state_d = S_WAIT_LOCK;
            end
            // Lock is checked before the timeout so a lock arriving on the last cycle wins.
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (tmr_q == TMO_LAST) begin
                    state_d = S_PLL_RST;
                    tmo_inc = 1'b1;
                end
            end
            S_STABLE: begin
                if (!locked_s) state_d = S_WAIT_LOCK;
                else if (tmr_q == STB_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                tmr_d = tmr_q;
                if (!locked_s) begin
                    state_d  = S_PLL_RST;
                    loss_inc = 1'b1;
                end
            end
            default: state_d = S_PLL_RST;
        endcase
        if (state_d != state_q) tmr_d = '0;

        // Outputs follow the next state so they change on the same edge as the state register.
        pll_rst_d = (state_d == S_PLL_RST);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);

        loss_cnt_d = loss_cnt_q;
        if (loss_inc && (loss_cnt_q != CNT_MAX)) loss_cnt_d = loss_cnt_q + CNT_W'(1);
        timeout_cnt_d = timeout_cnt_q;
        if (tmo_inc && (timeout_cnt_q != CNT_MAX)) timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_PLL_RST;
            tmr_q         <= '0;
            sync_q        <= '0;
            pll_rst_q     <= 1'b1;
            sys_rst_q     <= 1'b1;
            ready_q       <= 1'b0;
            loss_cnt_q    <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            sync_q        <= sync_d;
            pll_rst_q     <= pll_rst_d;
            sys_rst_q     <= sys_rst_d;
            ready_q       <= ready_d;
            loss_cnt_q    <= loss_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst     = sys_rst_q;
    assign ready       = ready_q;
    assign loss_cnt    = loss_cnt_q;
    assign timeout_cnt = timeout_cnt_q;

endmodule
